// File: rtl/baud_tick_gen_if.sv
// rtl/baud_tick_gen_if.sv - control/tick bundle for baud_tick_gen; mid_tick present only with BAUD_TICK_GEN_MID_EN
interface baud_tick_gen_if #(
  parameter int BAUD_W  = 24,
  parameter int OS_LOG2 = 3
);
  localparam int PH_W = (OS_LOG2 > 0) ? OS_LOG2 : 1;

  logic              en;
  logic              restart;
  logic              baud_wr;
  logic [BAUD_W-1:0] baud_val;
  logic              os_tick;
  logic              bit_tick;
  logic [PH_W-1:0]   os_phase;
  logic              busy;
  logic              baud_err;
  logic [BAUD_W-1:0] cur_baud;
`ifdef BAUD_TICK_GEN_MID_EN
  logic              mid_tick;
`endif

  modport master (
    output en, restart, baud_wr, baud_val,
    input  os_tick, bit_tick, os_phase, busy, baud_err, cur_baud
`ifdef BAUD_TICK_GEN_MID_EN
    , input mid_tick
`endif
  );

  modport slave (
    input  en, restart, baud_wr, baud_val,
    output os_tick, bit_tick, os_phase, busy, baud_err, cur_baud
`ifdef BAUD_TICK_GEN_MID_EN
    , output mid_tick
`endif
  );
endinterface

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - runtime-programmable fractional baud tick generator; optional mid_tick via BAUD_TICK_GEN_MID_EN
module baud_tick_gen #(
  parameter int CLK_RATE     = 50_000_000,
  parameter int DEFAULT_BAUD = 115_200,
  parameter int OS_LOG2      = 3,
  parameter int BAUD_W       = 24
) (
  input  logic           clk,
  input  logic           rst_n,
  baud_tick_gen_if.slave bus
);
  localparam int PH_W  = (OS_LOG2 > 0) ? OS_LOG2 : 1;
  localparam int INC_W = BAUD_W + OS_LOG2;
  localparam int ACC_W = $clog2(CLK_RATE) + 1;
  // one spare bit so acc + inc can never overflow before the wrap compare
  localparam int CMP_W = ACC_W + 1;

  localparam logic [CMP_W-1:0] CLK_C   = CMP_W'(CLK_RATE);
  localparam logic [63:0]      CLK_64  = 64'(CLK_RATE);
  localparam logic [PH_W-1:0]  PH_ONE  = PH_W'(1);
  localparam logic [PH_W-1:0]  PH_LAST = PH_W'((1 << OS_LOG2) - 1);
`ifdef BAUD_TICK_GEN_MID_EN
  localparam logic [PH_W-1:0]  PH_MID  = (OS_LOG2 == 0) ? PH_W'(0) :
                                         PH_W'(1 << ((OS_LOG2 > 0) ? OS_LOG2 - 1 : 0));
  // half-oversample preload centres sampling on the detected start edge
  localparam logic [ACC_W-1:0] RST_ACC = ACC_W'(CLK_RATE / 2);
`else
  localparam logic [ACC_W-1:0] RST_ACC = '0;
`endif

  logic [ACC_W-1:0]  acc;
  logic [PH_W-1:0]   os_phase;
  logic [PH_W-1:0]   ph_nxt;
  logic              os_tick;
  logic              bit_tick;
  logic              busy;
  logic              baud_err;
  logic [BAUD_W-1:0] cur_baud;
  logic [BAUD_W-1:0] pend;
  logic [INC_W-1:0]  inc;
  logic [INC_W-1:0]  inc_new;
  logic [CMP_W-1:0]  sum;
  logic              wrap;
  logic              bit_edge;
  logic              wr_ok;
  logic              wr_acc;
`ifdef BAUD_TICK_GEN_MID_EN
  logic              mid_tick;
`endif

  assign inc      = INC_W'(cur_baud) << OS_LOG2;
  assign sum      = {1'b0, acc} + CMP_W'(inc);
  assign wrap     = (sum >= CLK_C);
  // with no oversampling the phase never moves, so every os_tick is a bit tick
  assign ph_nxt   = (OS_LOG2 == 0) ? PH_W'(0) : os_phase + PH_ONE;
  assign bit_edge = bus.en && !bus.restart && wrap && (os_phase == PH_LAST);

  // more than one oversample tick per clock cannot be represented
  assign inc_new  = INC_W'(bus.baud_val) << OS_LOG2;
  assign wr_ok    = (bus.baud_val != '0) && (64'(inc_new) <= CLK_64);
  assign wr_acc   = bus.baud_wr && wr_ok;

  // phase accumulator, oversample/bit ticks and phase index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      os_phase <= '0;
      os_tick  <= 1'b0;
      bit_tick <= 1'b0;
`ifdef BAUD_TICK_GEN_MID_EN
      mid_tick <= 1'b0;
`endif
    end else if (!bus.en) begin
      acc      <= '0;
      os_phase <= '0;
      os_tick  <= 1'b0;
      bit_tick <= 1'b0;
`ifdef BAUD_TICK_GEN_MID_EN
      mid_tick <= 1'b0;
`endif
    end else if (bus.restart) begin
      acc      <= RST_ACC;
      os_phase <= '0;
      os_tick  <= 1'b0;
      bit_tick <= 1'b0;
`ifdef BAUD_TICK_GEN_MID_EN
      mid_tick <= 1'b0;
`endif
    end else if (wrap) begin
      acc      <= ACC_W'(sum - CLK_C);
      os_phase <= ph_nxt;
      os_tick  <= 1'b1;
      bit_tick <= (os_phase == PH_LAST);
`ifdef BAUD_TICK_GEN_MID_EN
      mid_tick <= (ph_nxt == PH_MID);
`endif
    end else begin
      acc      <= ACC_W'(sum);
      os_tick  <= 1'b0;
      bit_tick <= 1'b0;
`ifdef BAUD_TICK_GEN_MID_EN
      mid_tick <= 1'b0;
`endif
    end
  end

  // baud register, pending update and write rejection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_baud <= BAUD_W'(DEFAULT_BAUD);
      pend     <= '0;
      busy     <= 1'b0;
      baud_err <= 1'b0;
    end else begin
      baud_err <= bus.baud_wr && !wr_ok;
      if (!bus.en) begin
        // idle generator: no bit boundary to wait for, apply at once
        busy <= 1'b0;
        if (wr_acc) begin
          cur_baud <= bus.baud_val;
        end else if (busy) begin
          cur_baud <= pend;
        end
      end else begin
        if (bit_edge && busy) begin
          cur_baud <= pend;
          busy     <= 1'b0;
        end
        // a write landing on a boundary waits for the following one
        if (wr_acc) begin
          pend <= bus.baud_val;
          busy <= 1'b1;
        end
      end
    end
  end

  assign bus.os_tick  = os_tick;
  assign bus.bit_tick = bit_tick;
  assign bus.os_phase = os_phase;
  assign bus.busy     = busy;
  assign bus.baud_err = baud_err;
  assign bus.cur_baud = cur_baud;
`ifdef BAUD_TICK_GEN_MID_EN
  assign bus.mid_tick = mid_tick;
`endif
endmodule

// File: doc/baud_tick_gen.md
Name: baud_tick_gen

Overview:
- Parametrised, runtime-programmable fractional baud generator; successor to the fixed-rate 8x tick generator.
- Produces an oversample tick, a 1x bit tick and a phase index for UART TX/RX datapaths.
- Baud rate is writable at runtime. Updates are applied glitch-free on bit boundaries.
- Supports an RX phase restart for start-bit alignment.

Parameters:
- CLK_RATE, 50_000_000: input clock frequency in Hz.
- DEFAULT_BAUD, 115_200: active baud rate after reset.
- OS_LOG2, 3: log2 of the oversample factor; 3 gives 8x. Legal range 0..5.
- BAUD_W, 24: width of the baud write and readback ports.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  generator enable; low synchronously clears phase state
- restart  in  1  single-cycle pulse; zeroes accumulator and phase (RX start-bit resync)
- baud_wr  in  1  write strobe for baud_val
- baud_val  in  BAUD_W  requested baud rate in Hz
- os_tick  out  1  oversample tick, one-cycle pulse
- bit_tick  out  1  bit-boundary tick, one-cycle pulse, coincident with the os_tick that wraps phase
- os_phase  out  OS_LOG2 (min 1)  oversample index within the current bit
- busy  out  1  a baud update is pending
- baud_err  out  1  one-cycle pulse when a write is rejected
- cur_baud  out  BAUD_W  active baud rate

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous, active-low.
- Reset values: acc=0, os_phase=0, os_tick=0, bit_tick=0, busy=0, baud_err=0, cur_baud=DEFAULT_BAUD.
- Sizing:
  - inc = cur_baud << OS_LOG2, computed at BAUD_W+OS_LOG2 bits.
  - Accumulator is sized by $clog2(CLK_RATE)+1. Compare/subtract is done at one extra bit; no overflow is permitted.
- Per clock, when en=1 and restart=0:
  - sum = acc + inc.
  - If sum >= CLK_RATE: acc<=sum-CLK_RATE, os_tick<=1, os_phase<=os_phase+1 (wrapping at 2^OS_LOG2), bit_tick<=(os_phase==2^OS_LOG2-1).
  - Otherwise: acc<=sum, os_tick<=0, bit_tick<=0.
- All outputs are registered. A tick is visible the cycle after the accumulating edge.
- Long-run rate: os_tick count over N clocks = floor(N*inc/CLK_RATE), with ±1 jitter per interval. No cumulative drift.
- en=0: acc<=0, os_phase<=0, ticks<=0 (synchronous clear). busy and cur_baud are held, except for pending-update handling below.
- restart=1 with en=1: acc<=0, os_phase<=0, ticks<=0 that cycle. restart has priority over accumulation. A pending update is not applied by restart.
- Write validation:
  - A write is rejected if baud_val==0 or inc_new > CLK_RATE (more than one tick per clock).
  - On rejection: baud_err pulses the next cycle; the pending register and busy are unchanged.
- Accepted write while en=1:
  - pend<=baud_val, busy<=1.
  - The update is applied on the edge that registers bit_tick=1: cur_baud<=pend, busy<=0. That same edge's accumulation uses the old inc; the new inc is used from the next cycle. acc residual is kept.
  - A write in the same cycle as a bit boundary is deferred to the next boundary.
  - A write while busy=1 overwrites pend; latest wins.
- Accepted write while en=0: cur_baud<=baud_val on the next edge; busy stays 0.
- Pending update when en falls: applied on the first cycle with en=0.
- OS_LOG2=0: os_phase is tied to 0 and bit_tick equals os_tick.
- Reset asserted mid-operation: all state returns to reset values immediately; pend is discarded.

Optional Feature:
- Macro: BAUD_TICK_GEN_MID_EN.
- When defined:
  - Adds output mid_tick (1 bit), a one-cycle pulse on the os_tick whose new os_phase equals 2^(OS_LOG2-1). This is the RX data-sampling point.
  - restart additionally preloads acc with CLK_RATE/2 (integer), so the first os_tick arrives half an oversample early. This centres sampling on the detected start edge.
- When not defined: no mid_tick port; restart zeroes acc only.
- With OS_LOG2=0, mid_tick equals os_tick.

Test Plan:
- Exact-rate check. Params CLK_RATE=16, DEFAULT_BAUD=1, OS_LOG2=2; en=1 after reset -> os_tick every 4 clocks, bit_tick every 16 clocks, os_phase cycling 1,2,3,0, bit_tick coincident with phase 0.
- Fractional accuracy. Defaults, en=1 for 1,000,000 clocks -> 18432 os_ticks and 2304 bit_ticks exactly; all os_tick intervals are 54 or 55 clocks.
- Deferred update. Defaults running, write 9600 mid-bit -> busy=1 until the edge registering bit_tick; then cur_baud=9600, busy=0, next os_tick intervals 651/652 clocks; no short bit observed.
- Rejection. Write 0, then write 8_000_000 (inc 64e6 > 50e6) -> baud_err pulses once per write; cur_baud stays 115200; busy unchanged.
- Restart and disable.
  - restart asserted mid-bit -> os_phase=0, no tick that cycle; next os_tick exactly 55 clocks later (acc=0, 54.25 ratio).
  - en low for 3 cycles -> ticks 0, phase 0, cur_baud held.
- Async reset mid-pending. Write 9600 then assert rst_n=0 between clock edges -> outputs return to reset values immediately; after release cur_baud=115200, busy=0.
- Optional feature (BAUD_TICK_GEN_MID_EN). Defaults, restart -> first os_tick after 28 clocks; mid_tick on phase 4 of each bit.
